wb_bus_arbiter: RTL

Two-master Wishbone (classic) arbiter that shares the user-project peripheral bus (timer/PWM, UART, SRAM decoder) between the management-SoC Wishbone port (master 0) and an on-chip DMA/accelerator master (master 1). It sits between the two masters and the existing address decoder, granting the bus round-robin and holding the grant for a whole `cyc` tenure. A per-access watchdog terminates any slave access that never acks, so one hung peripheral cannot deadlock either master.

---
 rtl/wb_arb_pkg.sv | 39 +++
 rtl/wb_arb_watchdog.sv | 37 +++
 rtl/wb_bus_arbiter.sv | 130 +++++++++++++
 3 files changed

// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

    localparam int unsigned ADR_W = 32;
    localparam int unsigned DAT_W = 32;
    localparam int unsigned SEL_W = 4;

    localparam logic [DAT_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_e;

    typedef struct packed {
        logic             cyc;
        logic             stb;
        logic             we;
        logic [SEL_W-1:0] sel;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
    } wb_req_t;

    // Round-robin pick: on contention the master not served last wins.
    function automatic arb_state_e arbitrate(input logic req0, input logic req1, input logic last);
        arb_state_e pick;
        pick = IDLE;
        if (req0 && req1) begin
            pick = last ? OWN0 : OWN1;
        end else if (req0) begin
            pick = OWN0;
        end else if (req1) begin
            pick = OWN1;
        end
        return pick;
    endfunction

endpackage

// File: rtl/wb_arb_watchdog.sv
// Per-access wait counter; flags expiry when a strobe has waited TIMEOUT cycles.
module wb_arb_watchdog #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // TIMEOUT of zero disables termination entirely.
    assign expire = (TIMEOUT != 32'd0) && en && (cnt_q == CNT_W'(TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (clr || expire) begin
            cnt_d = '0;
        end else if (en && (TIMEOUT != 32'd0)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_bus_arbiter.sv
// Two-master round-robin Wishbone classic arbiter with tenure lock and
// per-access watchdog termination.
module wb_bus_arbiter
    import wb_arb_pkg::*;
#(
    parameter int unsigned      TIMEOUT  = 255,
    parameter logic [DAT_W-1:0] ERR_DATA = ERR_DATA_DEFAULT
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_ni,

    input  logic             m0_cyc_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    output logic             m0_ack_o,
    output logic [DAT_W-1:0] m0_dat_o,

    input  logic             m1_cyc_i,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    output logic             m1_ack_o,
    output logic [DAT_W-1:0] m1_dat_o,

    output logic             s_cyc_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [SEL_W-1:0] s_sel_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    input  logic             s_ack_i,
    input  logic [DAT_W-1:0] s_dat_i,

    output logic [1:0]       grant_o,
    output logic             timeout_o
);

    arb_state_e state_q;
    arb_state_e state_d;
    logic       last_q;
    logic       last_d;

    wb_req_t    m0_bus;
    wb_req_t    m1_bus;
    wb_req_t    own_bus;

    logic       m0_req;
    logic       m1_req;
    logic       own_act;
    logic       wd_clr;
    logic       wd_en;
    logic       expire;

    assign m0_bus = {m0_cyc_i, m0_stb_i, m0_we_i, m0_sel_i, m0_adr_i, m0_dat_i};
    assign m1_bus = {m1_cyc_i, m1_stb_i, m1_we_i, m1_sel_i, m1_adr_i, m1_dat_i};
    assign m0_req = m0_cyc_i & m0_stb_i;
    assign m1_req = m1_cyc_i & m1_stb_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
        end
    end

    // Owner keeps the bus for its whole cyc tenure; release re-arbitrates in the same cycle.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        case (state_q)
            IDLE:    state_d = arbitrate(m0_req, m1_req, last_q);
            OWN0:    if (!m0_cyc_i) state_d = arbitrate(m0_req, m1_req, last_q);
            OWN1:    if (!m1_cyc_i) state_d = arbitrate(m0_req, m1_req, last_q);
            default: state_d = IDLE;
        endcase
        if (state_d == OWN0) begin
            last_d = 1'b0;
        end else if (state_d == OWN1) begin
            last_d = 1'b1;
        end
    end

    always_comb begin
        own_bus = '0;
        case (state_q)
            OWN0:    own_bus = m0_bus;
            OWN1:    own_bus = m1_bus;
            default: own_bus = '0;
        endcase
    end

    assign own_act = own_bus.cyc & own_bus.stb;
    assign wd_en   = own_act & ~s_ack_i;
    assign wd_clr  = ~own_act | s_ack_i | (state_d != state_q);

    wb_arb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk    (wb_clk_i),
        .rst_n  (wb_rst_ni),
        .clr    (wd_clr),
        .en     (wd_en),
        .expire (expire)
    );

    assign s_cyc_o   = own_bus.cyc;
    assign s_stb_o   = own_bus.stb & ~expire;
    assign s_we_o    = own_bus.we;
    assign s_sel_o   = own_bus.sel;
    assign s_adr_o   = own_bus.adr;
    assign s_dat_o   = own_bus.dat;

    assign grant_o   = {state_q == OWN1, state_q == OWN0};
    assign timeout_o = expire;

    // A real ack always beats the watchdog since expire requires s_ack_i low.
    assign m0_ack_o  = (state_q == OWN0) & (s_ack_i | expire);
    assign m1_ack_o  = (state_q == OWN1) & (s_ack_i | expire);
    assign m0_dat_o  = (state_q == OWN0) ? (expire ? ERR_DATA : s_dat_i) : '0;
    assign m1_dat_o  = (state_q == OWN1) ? (expire ? ERR_DATA : s_dat_i) : '0;

endmodule
